// File: rtl/stopwatch_pkg.sv
// Shared encodings and BCD digit limits for the MM:SS stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] UNITS_MAX = 4'd9;
    localparam logic [BCD_W-1:0] SEC10_MAX = 4'd5;
    localparam logic [BCD_W-1:0] MIN10_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_ctrl_rise_detect.sv
// Rising-edge detector for a Clk-synchronous level; an input already high when
// reset releases is absorbed into the history instead of reporting an edge.
module rise_detect (
    input  logic Clk,
    input  logic Rst,
    input  logic In,
    output logic Rise
);

    logic hist_q;
    logic armed_q;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            hist_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            hist_q  <= In;
            armed_q <= 1'b1;
        end
    end

    // armed_q masks the first sample after reset so a held level is not an edge
    assign Rise = In & ~hist_q & armed_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS BCD stopwatch: ClkDivIn rises (prescaled) advance the count while running;
// StartStop toggles run/pause, Clear returns to IDLE at 00:00.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_INC = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ClkDivIn,
    input  logic             StartStop,
    input  logic             Clear,
    output logic [BCD_W-1:0] Sec1,
    output logic [BCD_W-1:0] Sec10,
    output logic [BCD_W-1:0] Min1,
    output logic [BCD_W-1:0] Min10,
    output logic             Running,
    output logic             Wrap
);

    localparam logic [7:0] TICKS_LIM = 8'(TICKS_PER_INC);

    sw_state_e        state_q, state_n;
    logic             running_q;
    logic             wrap_q;
    logic [7:0]       presc_q;
    logic [BCD_W-1:0] sec1_q, sec10_q, min1_q, min10_q;
    logic             div_rise, ss_rise, clr_rise;
    logic             tick_en, inc, at_max;

    rise_detect u_div_rise (.Clk(Clk), .Rst(Rst), .In(ClkDivIn),  .Rise(div_rise));
    rise_detect u_ss_rise  (.Clk(Clk), .Rst(Rst), .In(StartStop), .Rise(ss_rise));
    rise_detect u_clr_rise (.Clk(Clk), .Rst(Rst), .In(Clear),     .Rise(clr_rise));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            running_q <= (state_n == RUN);
        end
    end

    always_comb begin
        state_n = state_q;
        if (clr_rise) begin
            state_n = IDLE;
        end else if (ss_rise) begin
            case (state_q)
                IDLE:    state_n = RUN;
                RUN:     state_n = PAUSE;
                PAUSE:   state_n = RUN;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        Running = running_q;
        Wrap    = wrap_q;
        Sec1    = sec1_q;
        Sec10   = sec10_q;
        Min1    = min1_q;
        Min10   = min10_q;
    end

    // Clear and StartStop both outrank a count tick at the same edge
    assign tick_en = div_rise & (state_q == RUN) & ~clr_rise & ~ss_rise;
    assign inc     = tick_en & ((presc_q + 8'd1) == TICKS_LIM);
    assign at_max  = (sec1_q == UNITS_MAX) & (sec10_q == SEC10_MAX) &
                     (min1_q == UNITS_MAX) & (min10_q == MIN10_MAX);

    always_ff @(posedge Clk) begin
        if (!Rst || clr_rise) begin
            presc_q <= 8'd0;
            sec1_q  <= '0;
            sec10_q <= '0;
            min1_q  <= '0;
            min10_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= inc & at_max;
            if (tick_en) begin
                presc_q <= inc ? 8'd0 : presc_q + 8'd1;
            end
            if (inc) begin
                if (sec1_q != UNITS_MAX) begin
                    sec1_q <= sec1_q + 4'd1;
                end else begin
                    sec1_q <= '0;
                    if (sec10_q != SEC10_MAX) begin
                        sec10_q <= sec10_q + 4'd1;
                    end else begin
                        sec10_q <= '0;
                        if (min1_q != UNITS_MAX) begin
                            min1_q <= min1_q + 4'd1;
                        end else begin
                            min1_q <= '0;
                            min10_q <= (min10_q != MIN10_MAX) ? min10_q + 4'd1 : '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (1 and 4 ticks per second) compared each
// cycle against a seconds-counter reference model, plus directed scenario checks.
module tb_stopwatch_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst, ClkDivIn, StartStop, Clear;
    logic [3:0] sec1 [2];
    logic [3:0] sec10[2];
    logic [3:0] min1 [2];
    logic [3:0] min10[2];
    logic       running[2];
    logic       wrap[2];

    stopwatch_ctrl #(.TICKS_PER_INC(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .ClkDivIn(ClkDivIn), .StartStop(StartStop), .Clear(Clear),
        .Sec1(sec1[0]), .Sec10(sec10[0]), .Min1(min1[0]), .Min10(min10[0]),
        .Running(running[0]), .Wrap(wrap[0])
    );

    stopwatch_ctrl #(.TICKS_PER_INC(4)) u_dut4 (
        .Clk(Clk), .Rst(Rst), .ClkDivIn(ClkDivIn), .StartStop(StartStop), .Clear(Clear),
        .Sec1(sec1[1]), .Sec10(sec10[1]), .Min1(min1[1]), .Min10(min10[1]),
        .Running(running[1]), .Wrap(wrap[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=run 2=pause, time kept as plain seconds 0..3599
    int tpi    [2] = '{1, 4};
    int m_mode [2];
    int m_secs [2];
    int m_presc[2];
    bit m_wrap [2];
    bit h_div, h_ss, h_clr, armed;

    function automatic logic [15:0] exp_digits(input int secs);
        int s, m;
        s = secs % 60;
        m = secs / 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_update(input bit rst_n, input bit div, input bit ss, input bit clr);
        bit dr, sr, cr;
        if (!rst_n) begin
            {h_div, h_ss, h_clr, armed} = '0;
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_secs[i] = 0; m_presc[i] = 0; m_wrap[i] = 0;
            end
            return;
        end
        dr = armed & div & ~h_div;
        sr = armed & ss & ~h_ss;
        cr = armed & clr & ~h_clr;
        {h_div, h_ss, h_clr, armed} = {div, ss, clr, 1'b1};
        for (int i = 0; i < 2; i++) begin
            m_wrap[i] = 0;
            if (cr) begin
                m_mode[i] = 0; m_secs[i] = 0; m_presc[i] = 0;
            end else if (sr) begin
                m_mode[i] = (m_mode[i] == 1) ? 2 : 1;
            end else if (dr && m_mode[i] == 1) begin
                m_presc[i]++;
                if (m_presc[i] == tpi[i]) begin
                    m_presc[i] = 0;
                    m_secs[i]++;
                    if (m_secs[i] == 3600) begin
                        m_secs[i] = 0;
                        m_wrap[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("digits%0d", i), {min10[i], min1[i], sec10[i], sec1[i]},
                      exp_digits(m_secs[i]));
            check_val($sformatf("running%0d", i), running[i], m_mode[i] == 1);
            check_val($sformatf("wrap%0d", i), wrap[i], m_wrap[i]);
        end
        check_val("presc1", u_dut1.presc_q, m_presc[0]);
        check_val("presc4", u_dut4.presc_q, m_presc[1]);
    endtask

    task automatic step(input bit rst_n, input bit div, input bit ss, input bit clr);
        Rst = rst_n; ClkDivIn = div; StartStop = ss; Clear = clr;
        @(posedge Clk);
        model_update(rst_n, div, ss, clr);
        #1;
        compare_all();
        @(negedge Clk);
    endtask

    task automatic rises(input int n);
        repeat (n) begin
            step(1, 1, 0, 0);
            step(1, 0, 0, 0);
        end
    endtask

    task automatic press_ss();
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
    endtask

    task automatic press_clr();
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
    endtask

    initial begin
        Rst = 1'b0; ClkDivIn = 1'b0; StartStop = 1'b0; Clear = 1'b0;
        @(negedge Clk);

        // reset held with ClkDivIn toggling, released with StartStop already high
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check_val("rst_digits", {min10[0], min1[0], sec10[0], sec1[0]}, 16'h0000);
        check_val("rst_running", running[0], 1'b0);
        step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        check_val("rel_held_ss", running[0], 1'b0);
        step(1, 0, 0, 0);

        press_ss();
        rises(12);
        check_val("run12_running", running[0], 1'b1);
        check_val("run12_digits", {min10[0], min1[0], sec10[0], sec1[0]}, 16'h0012);

        press_clr();
        press_ss();
        rises(7);
        press_ss();
        rises(5);
        check_val("pause_hold", {min10[0], min1[0], sec10[0], sec1[0]}, 16'h0007);
        check_val("pause_running", running[0], 1'b0);
        press_ss();
        rises(2);
        check_val("resume_digits", {min10[0], min1[0], sec10[0], sec1[0]}, 16'h0009);

        press_clr();
        press_ss();
        rises(3598);
        check_val("pre_wrap", {min10[0], min1[0], sec10[0], sec1[0]}, 16'h5958);
        rises(1);
        check_val("at_5959", {min10[0], min1[0], sec10[0], sec1[0]}, 16'h5959);
        step(1, 1, 0, 0);
        check_val("wrap_pulse", wrap[0], 1'b1);
        check_val("wrap_digits", {min10[0], min1[0], sec10[0], sec1[0]}, 16'h0000);
        check_val("wrap_running", running[0], 1'b1);
        step(1, 0, 0, 0);
        check_val("wrap_one_cycle", wrap[0], 1'b0);
        rises(5);
        step(1, 1, 0, 1);
        check_val("clr_rise_digits", {min10[0], min1[0], sec10[0], sec1[0]}, 16'h0000);
        check_val("clr_rise_running", running[0], 1'b0);
        step(1, 0, 0, 0);

        press_ss();
        rises(10);
        check_val("tpi4_sec1", sec1[1], 4'd2);
        check_val("tpi4_presc", u_dut4.presc_q, 8'd2);
        step(1, 0, 0, 1);
        check_val("tpi4_presc_clr", u_dut4.presc_q, 8'd0);
        step(1, 0, 0, 0);
        press_ss();
        rises(4);
        check_val("tpi4_restart", sec1[1], 4'd1);

        press_clr();
        press_ss();
        rises(221);
        check_val("at_0341", {min10[0], min1[0], sec10[0], sec1[0]}, 16'h0341);
        step(0, 0, 0, 0);
        check_val("midrun_rst_digits", {min10[0], min1[0], sec10[0], sec1[0]}, 16'h0000);
        check_val("midrun_rst_running", running[0], 1'b0);
        step(1, 0, 0, 0);
        rises(3);
        check_val("idle_no_count", {min10[0], min1[0], sec10[0], sec1[0]}, 16'h0000);

        // Clear landing on the wrapping increment
        press_ss();
        rises(3599);
        step(1, 1, 0, 1);
        check_val("clr_wrap_wrap", wrap[0], 1'b0);
        check_val("clr_wrap_digits", {min10[0], min1[0], sec10[0], sec1[0]}, 16'h0000);
        step(1, 0, 0, 0);

        repeat (3000) begin
            step(($urandom_range(0, 255) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
